// File: rtl/step_pulse_gen.sv
// Step pulse generator: fixed-rate walk/jog/run modes plus a table-driven hybrid profile.
// Optional step counter output enabled by defining STEP_PULSE_GEN_STEPCNT_EN.
module step_pulse_gen #(
    parameter int CNT_W     = 24,
    parameter int SEC_TICKS = 100000000,
    parameter int SEGS      = 8,
    parameter int WALK_HALF = 1562500,
    parameter int JOG_HALF  = 781250,
    parameter int RUN_HALF  = 390625,
    localparam int ADDR_W   = $clog2(SEGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic [7:0]        cfg_secs,
    output logic              pulse,
    output logic              pulsestart,
    output logic              done,
    output logic [ADDR_W-1:0] seg_idx
`ifdef STEP_PULSE_GEN_STEPCNT_EN
    ,
    output logic [15:0]       step_count
`endif
);

    localparam int TICK_W = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SEC_TICKS - 1);

    localparam logic [CNT_W-1:0] WALK_H = CNT_W'(WALK_HALF);
    localparam logic [CNT_W-1:0] JOG_H  = CNT_W'(JOG_HALF);
    localparam logic [CNT_W-1:0] RUN_H  = CNT_W'(RUN_HALF);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FIXED = 2'd1;
    localparam logic [1:0] HYB   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] MODE_HYBRID = 2'b11;

    logic [1:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] seg_idx_q, seg_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cur_half_q, cur_half_d;
    logic              pulse_q, pulse_d;
    logic              run_q, run_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [7:0]        sec_q, sec_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  half_tab_q [SEGS];
    logic [CNT_W-1:0]  half_tab_d [SEGS];
    logic [7:0]        secs_tab_q [SEGS];
    logic [7:0]        secs_tab_d [SEGS];

    logic              first_found;
    logic [ADDR_W-1:0] first_seg;
    logic              next_found;
    logic [ADDR_W-1:0] next_seg;
    logic [CNT_W-1:0]  active_half;

    function automatic logic [CNT_W-1:0] fixed_half(input logic [1:0] m);
        case (m)
            2'b00:   fixed_half = WALK_H;
            2'b01:   fixed_half = JOG_H;
            2'b10:   fixed_half = RUN_H;
            default: fixed_half = '0;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        half_tab_d = half_tab_q;
        secs_tab_d = secs_tab_q;
        if (cfg_we) begin
            half_tab_d[cfg_addr] = cfg_half;
            secs_tab_d[cfg_addr] = cfg_secs;
        end
    end

    // Descending scan so the lowest qualifying index wins.
    always_comb begin
        first_found = 1'b0;
        first_seg   = '0;
        next_found  = 1'b0;
        next_seg    = '0;
        for (int i = SEGS - 1; i >= 0; i--) begin
            if (secs_tab_q[i] != 8'd0) begin
                first_found = 1'b1;
                first_seg   = ADDR_W'(i);
                if (i > int'(seg_idx_q)) begin
                    next_found = 1'b1;
                    next_seg   = ADDR_W'(i);
                end
            end
        end
    end

    assign active_half = (state_q == HYB) ? half_tab_q[seg_idx_q] : fixed_half(mode_q);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        seg_idx_d  = seg_idx_q;
        cnt_d      = cnt_q;
        cur_half_d = cur_half_q;
        pulse_d    = pulse_q;
        run_d      = run_q;
        tick_d     = tick_q;
        sec_d      = sec_q;

        if (!start) begin
            state_d    = IDLE;
            seg_idx_d  = '0;
            cnt_d      = '0;
            cur_half_d = '0;
            pulse_d    = 1'b0;
            run_d      = 1'b0;
            tick_d     = '0;
            sec_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    mode_d    = mode;
                    seg_idx_d = '0;
                    if (mode != MODE_HYBRID) begin
                        state_d = FIXED;
                    end else if (first_found) begin
                        state_d   = HYB;
                        seg_idx_d = first_seg;
                    end else begin
                        state_d = DONE;
                    end
                end

                FIXED, HYB: begin
                    // A phase is armed only with a non-zero half; a silent segment re-checks every cycle.
                    if (!run_q) begin
                        run_d      = (active_half != '0);
                        pulse_d    = (active_half != '0);
                        cnt_d      = '0;
                        cur_half_d = active_half;
                    end else if (cnt_q == cur_half_q - CNT_W'(1)) begin
                        cnt_d      = '0;
                        cur_half_d = active_half;
                        if (active_half == '0) begin
                            pulse_d = 1'b0;
                            run_d   = 1'b0;
                        end else begin
                            pulse_d = ~pulse_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end

                    if (state_q == HYB) begin
                        if (tick_q == TICK_LAST) begin
                            tick_d = '0;
                            if (sec_q + 8'd1 == secs_tab_q[seg_idx_q]) begin
                                sec_d      = '0;
                                cnt_d      = '0;
                                cur_half_d = '0;
                                pulse_d    = 1'b0;
                                run_d      = 1'b0;
                                if (next_found) begin
                                    seg_idx_d = next_seg;
                                end else begin
                                    state_d = DONE;
                                end
                            end else begin
                                sec_d = sec_q + 8'd1;
                            end
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end
                end

                default: begin
                    pulse_d = 1'b0;
                    run_d   = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end

        done_d = (state_d == DONE) && (state_q != DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= 2'b00;
            seg_idx_q  <= '0;
            cnt_q      <= '0;
            cur_half_q <= '0;
            pulse_q    <= 1'b0;
            run_q      <= 1'b0;
            tick_q     <= '0;
            sec_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            seg_idx_q  <= seg_idx_d;
            cnt_q      <= cnt_d;
            cur_half_q <= cur_half_d;
            pulse_q    <= pulse_d;
            run_q      <= run_d;
            tick_q     <= tick_d;
            sec_q      <= sec_d;
            done_q     <= done_d;
        end
    end

    // NOTE: the profile table is built from flops, not RAM, because reset must reload its default contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SEGS; i++) begin
                half_tab_q[i] <= (i == 0) ? WALK_H : '0;
                secs_tab_q[i] <= (i == 0) ? 8'd1 : 8'd0;
            end
        end else begin
            for (int i = 0; i < SEGS; i++) begin
                half_tab_q[i] <= half_tab_d[i];
                secs_tab_q[i] <= secs_tab_d[i];
            end
        end
    end

    assign pulse      = pulse_q;
    assign pulsestart = (state_q != IDLE);
    assign done       = done_q;
    assign seg_idx    = seg_idx_q;

`ifdef STEP_PULSE_GEN_STEPCNT_EN
    logic [15:0] step_cnt_q, step_cnt_d;

    always_comb begin
        step_cnt_d = step_cnt_q;
        if (state_d == IDLE) begin
            step_cnt_d = '0;
        end else if (pulse_d && !pulse_q && (step_cnt_q != 16'hFFFF)) begin
            step_cnt_d = step_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt_q <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end

    assign step_count = step_cnt_q;
`else
    // Step counter not built.
`endif

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed testbench for step_pulse_gen with small timing parameters.
// Checks the step counter too when STEP_PULSE_GEN_STEPCNT_EN is defined.
module tb_step_pulse_gen;

    localparam int CNT_W     = 24;
    localparam int SEC_TICKS = 20;
    localparam int SEGS      = 8;
    localparam int AW        = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic             cfg_we = 1'b0;
    logic [AW-1:0]    cfg_addr = '0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic [7:0]       cfg_secs = '0;
    logic             pulse;
    logic             pulsestart;
    logic             done;
    logic [AW-1:0]    seg_idx;
`ifdef STEP_PULSE_GEN_STEPCNT_EN
    logic [15:0]      step_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    step_pulse_gen #(
        .CNT_W(CNT_W), .SEC_TICKS(SEC_TICKS), .SEGS(SEGS),
        .WALK_HALF(4), .JOG_HALF(3), .RUN_HALF(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_half(cfg_half), .cfg_secs(cfg_secs),
        .pulse(pulse), .pulsestart(pulsestart), .done(done), .seg_idx(seg_idx)
`ifdef STEP_PULSE_GEN_STEPCNT_EN
        , .step_count(step_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input int half, input int secs);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_half = CNT_W'(half);
        cfg_secs = 8'(secs);
        tick();
        cfg_we = 1'b0;
    endtask

    // Expected pulse k cycles after a phase start: low on k=0, then half high, half low.
    function automatic logic exp_phase(input int k, input int half);
        if (k == 0 || half == 0) return 1'b0;
        return (((k - 1) / half) % 2) == 0;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        mode  = 2'b00;
        tick();
        tick();
        n_checks++; if (pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got=%b exp=0", pulse); end
        n_checks++; if (pulsestart !== 1'b0) begin n_fail++; $display("FAIL reset_pulsestart got=%b exp=0", pulsestart); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (seg_idx !== '0) begin n_fail++; $display("FAIL reset_seg_idx got=%0d exp=0", seg_idx); end
        start = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_walk();
        logic exp;
        do_reset();
        mode  = 2'b00;
        start = 1'b1;
        for (int n = 0; n < 26; n++) begin
            tick();
            exp = exp_phase(n, 4);
            n_checks++; if (pulse !== exp) begin n_fail++; $display("FAIL walk_pulse n=%0d got=%b exp=%b", n, pulse, exp); end
            n_checks++; if (pulsestart !== 1'b1) begin n_fail++; $display("FAIL walk_pulsestart n=%0d got=%b exp=1", n, pulsestart); end
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_hybrid();
        logic exp;
        do_reset();
        cfg_write(0, 2, 1);
        cfg_write(1, 5, 2);
        cfg_write(2, 0, 0);
        mode  = 2'b11;
        start = 1'b1;
        for (int n = 0; n < 66; n++) begin
            tick();
            if (n < 20) exp = exp_phase(n, 2);
            else if (n < 60) exp = exp_phase(n - 20, 5);
            else exp = 1'b0;
            n_checks++; if (pulse !== exp) begin n_fail++; $display("FAIL hyb_pulse n=%0d got=%b exp=%b", n, pulse, exp); end
            n_checks++; if (done !== (n == 60)) begin n_fail++; $display("FAIL hyb_done n=%0d got=%b exp=%b", n, done, (n == 60)); end
            n_checks++; if (pulsestart !== 1'b1) begin n_fail++; $display("FAIL hyb_pulsestart n=%0d got=%b exp=1", n, pulsestart); end
            if (n < 60) begin
                n_checks++;
                if (seg_idx !== ((n < 20) ? AW'(0) : AW'(1))) begin
                    n_fail++; $display("FAIL hyb_seg_idx n=%0d got=%0d exp=%0d", n, seg_idx, (n < 20) ? 0 : 1);
                end
            end
        end
        start = 1'b0;
        tick();
        n_checks++; if (pulsestart !== 1'b0) begin n_fail++; $display("FAIL hyb_stop_idle got=%b exp=0", pulsestart); end
    endtask

    task automatic test_stop_restart();
        do_reset();
        mode  = 2'b00;
        start = 1'b1;
        tick();
        tick();
        tick();
        n_checks++; if (pulse !== 1'b1) begin n_fail++; $display("FAIL stop_pre_high got=%b exp=1", pulse); end
        start = 1'b0;
        tick();
        n_checks++; if (pulse !== 1'b0) begin n_fail++; $display("FAIL stop_pulse got=%b exp=0", pulse); end
        n_checks++; if (pulsestart !== 1'b0) begin n_fail++; $display("FAIL stop_pulsestart got=%b exp=0", pulsestart); end
        start = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            n_checks++;
            if (pulse !== exp_phase(n, 4)) begin
                n_fail++; $display("FAIL restart_pulse n=%0d got=%b exp=%b", n, pulse, exp_phase(n, 4));
            end
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic exp;
        do_reset();
        cfg_write(0, 2, 1);
        cfg_write(1, 5, 2);
        mode  = 2'b11;
        start = 1'b1;
        for (int n = 0; n < 31; n++) tick();
        n_checks++; if (seg_idx !== AW'(1)) begin n_fail++; $display("FAIL midrst_pre_seg got=%0d exp=1", seg_idx); end
        reset = 1'b1;
        tick();
        n_checks++; if (pulse !== 1'b0) begin n_fail++; $display("FAIL midrst_pulse got=%b exp=0", pulse); end
        n_checks++; if (pulsestart !== 1'b0) begin n_fail++; $display("FAIL midrst_pulsestart got=%b exp=0", pulsestart); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", done); end
        n_checks++; if (seg_idx !== '0) begin n_fail++; $display("FAIL midrst_seg_idx got=%0d exp=0", seg_idx); end
        reset = 1'b0;
        start = 1'b0;
        tick();
        // Restored table: only entry 0 = {4, 1 s}, so the profile ends after one second.
        start = 1'b1;
        for (int n = 0; n < 22; n++) begin
            tick();
            exp = (n < 20) ? exp_phase(n, 4) : 1'b0;
            n_checks++; if (pulse !== exp) begin n_fail++; $display("FAIL restored_pulse n=%0d got=%b exp=%b", n, pulse, exp); end
            n_checks++; if (done !== (n == 20)) begin n_fail++; $display("FAIL restored_done n=%0d got=%b exp=%b", n, done, (n == 20)); end
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_silent_and_lock();
        do_reset();
        cfg_write(0, 0, 1);
        mode  = 2'b11;
        start = 1'b1;
        for (int n = 0; n < 21; n++) begin
            tick();
            n_checks++; if (pulse !== 1'b0) begin n_fail++; $display("FAIL silent_pulse n=%0d got=%b exp=0", n, pulse); end
            n_checks++; if (done !== (n == 20)) begin n_fail++; $display("FAIL silent_done n=%0d got=%b exp=%b", n, done, (n == 20)); end
        end
        start = 1'b0;
        tick();
        // Every duration zero: straight to DONE.
        cfg_write(0, 0, 0);
        start = 1'b1;
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL allzero_done got=%b exp=1", done); end
        n_checks++; if (pulsestart !== 1'b1) begin n_fail++; $display("FAIL allzero_pulsestart got=%b exp=1", pulsestart); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL allzero_done_once got=%b exp=0", done); end
        n_checks++; if (pulse !== 1'b0) begin n_fail++; $display("FAIL allzero_pulse got=%b exp=0", pulse); end
        start = 1'b0;
        tick();
        // Jog latched; later mode changes must not alter the period.
        mode  = 2'b01;
        start = 1'b1;
        for (int n = 0; n < 21; n++) begin
            tick();
            if (n == 0) mode = 2'b10;
            if (n == 7) mode = 2'b00;
            n_checks++;
            if (pulse !== exp_phase(n, 3)) begin
                n_fail++; $display("FAIL lock_pulse n=%0d got=%b exp=%b", n, pulse, exp_phase(n, 3));
            end
        end
        start = 1'b0;
        tick();
    endtask

`ifdef STEP_PULSE_GEN_STEPCNT_EN
    task automatic test_step_count();
        do_reset();
        mode  = 2'b00;
        start = 1'b1;
        tick();
        n_checks++; if (step_count !== 16'd0) begin n_fail++; $display("FAIL stepcnt_start got=%0d exp=0", step_count); end
        for (int n = 1; n <= 80; n++) tick();
        n_checks++; if (step_count !== 16'd10) begin n_fail++; $display("FAIL stepcnt_ten got=%0d exp=10", step_count); end
        start = 1'b0;
        tick();
        n_checks++; if (step_count !== 16'd0) begin n_fail++; $display("FAIL stepcnt_idle got=%0d exp=0", step_count); end
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_walk();
        test_hybrid();
        test_stop_restart();
        test_reset_mid();
        test_silent_and_lock();
`ifdef STEP_PULSE_GEN_STEPCNT_EN
        test_step_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 SHALL provide parameter CNT_W, default 24: half-period counter width.
REQ-002 SHALL provide parameter SEC_TICKS, default 100000000: clk cycles per second.
REQ-003 SHALL provide parameter SEGS, default 8: hybrid profile segment count, power of two, 2..16.
REQ-004 SHALL provide parameters WALK_HALF 1562500, JOG_HALF 781250 and RUN_HALF 390625: half-periods for modes 00, 01 and 10.
REQ-005 SHALL provide port clk, input, 1: system clock, all logic on its rising edge.
REQ-006 SHALL provide port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL provide port start, input, 1: level; high runs, low stops.
REQ-008 SHALL provide port mode, input, 2: 00 walk, 01 jog, 10 run, 11 hybrid.
REQ-009 SHALL provide port cfg_we, input, 1: profile table write strobe.
REQ-010 SHALL provide port cfg_addr, input, log2(SEGS): segment index.
REQ-011 SHALL provide port cfg_half, input, CNT_W: segment half-period in cycles.
REQ-012 SHALL provide port cfg_secs, input, 8: segment duration in seconds.
REQ-013 SHALL provide port pulse, output, 1: generated step waveform.
REQ-014 SHALL provide port pulsestart, output, 1: high while the state is not IDLE.
REQ-015 SHALL provide port done, output, 1: one-cycle strobe on hybrid profile completion.
REQ-016 SHALL provide port seg_idx, output, log2(SEGS): active hybrid segment index.

Function
REQ-017 SHALL implement FSM states IDLE, FIXED, HYB and DONE.
REQ-018 SHALL, in IDLE with start=1, latch mode and next cycle enter FIXED for 00/01/10, or HYB at the first segment with cfg_secs!=0 for 11, or DONE if every segment duration is 0.
REQ-019 SHALL ignore mode changes outside IDLE.
REQ-020 SHALL, in any state with start=0, return to IDLE next cycle with pulse=0 and all counters cleared.
REQ-021 SHALL drive pulse high for half cycles then low for half cycles, period 2*half, with the first high cycle being the cycle after state entry.
REQ-022 SHALL hold pulse low for any segment whose half is 0, while its seconds still elapse.
REQ-023 SHALL, in HYB, count SEC_TICKS cycles per second and advance when the elapsed seconds equal cfg_secs, restarting the pulse phase high, skipping zero-duration segments and wrapping nothing.
REQ-024 SHALL, after the last non-zero segment, enter DONE, pulse done for exactly one cycle, hold pulse=0, and remain in DONE until start=0.
REQ-025 SHALL accept cfg_we in any state, writing the entry at the clock edge; a write to the active segment takes effect at its next half-period boundary.
REQ-026 SHALL perform all counter comparisons at CNT_W width with no overflow for half up to 2^CNT_W-1.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, force IDLE, pulse=0, pulsestart=0, done=0, seg_idx=0 and all counters to 0, overriding start, including mid-operation.
REQ-028 SHALL, on reset, load the profile table with entry 0 = {WALK_HALF, 1 s} and all other entries = {0, 0}.

Configuration
REQ-029 SHALL, with macro STEP_PULSE_GEN_STEPCNT_EN defined, add output step_count, 16 bits, counting pulse rising edges, saturating at 65535, cleared by reset or entry to IDLE.
REQ-030 SHALL, without STEP_PULSE_GEN_STEPCNT_EN, omit the port and all of its logic.

Verification
REQ-031 SHALL verify walk: WALK_HALF=4, mode=00, start=1 -> pulse 4 high, 4 low, repeating; pulsestart=1.
REQ-032 SHALL verify hybrid: SEC_TICKS=20, seg0={2,1}, seg1={5,2}, seg2={0,0}, rest zero, mode=11 -> seg0 for 20 cycles, seg1 for 40 cycles, then done=1 for one cycle and pulse=0.
REQ-033 SHALL verify mid-run stop: start deasserted mid-high phase -> pulse=0 and IDLE next cycle; restart begins phase high.
REQ-034 SHALL verify mid-run reset: reset during HYB seg1 -> all outputs 0 and the table restored to its reset contents.
REQ-035 SHALL verify silent segment and mode lock: seg0={0,1} keeps pulse low 1 s; changing mode during FIXED leaves the period unchanged.
REQ-036 SHALL verify the macro: with STEP_PULSE_GEN_STEPCNT_EN defined and 10 walk periods elapsed -> step_count=10.
